// File: rtl/uart_frac_baud_gen_pkg.sv
// Shared rate codes, table rates and the fixed-point divisor calculation
// used by the fractional UART baud/sample tick generator.
package uart_pkg;

  typedef enum logic [3:0] {
    BAUD_9600    = 4'd0,
    BAUD_19200   = 4'd1,
    BAUD_38400   = 4'd2,
    BAUD_57600   = 4'd3,
    BAUD_115200  = 4'd4,
    BAUD_230400  = 4'd5,
    BAUD_460800  = 4'd6,
    BAUD_921600  = 4'd7,
    BAUD_1843200 = 4'd8,
    BAUD_CUSTOM  = 4'd15
  } baud_sel_e;

  localparam int unsigned NUM_RATES = 9;

  localparam int unsigned BAUD_RATES [NUM_RATES] = '{
    9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600, 1843200
  };

  // Round-to-nearest of clk_freq * 2^frac_bits / (baud * os).
  function automatic longint unsigned baud_divisor(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input longint unsigned os,
    input longint unsigned frac_bits
  );
    longint unsigned den;
    den = baud * os;
    return ((clk_freq << frac_bits) + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_frac_baud_gen_divider.sv
// Period counter with fractional accumulator: emits one sample_tick every
// I or I+1 cycles so that the long-run period equals the fixed-point divisor.
module frac_tick_divider #(
  parameter int unsigned      DIV_W     = 18,
  parameter int unsigned      FRAC_BITS = 8,
  parameter logic [DIV_W-1:0] RST_DIV   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             sample_tick
);

  localparam int unsigned INT_W = DIV_W - FRAC_BITS;
  localparam logic [INT_W-1:0] RST_INT = RST_DIV[DIV_W-1:FRAC_BITS];

  logic [DIV_W-1:0]     div;
  logic [INT_W-1:0]     cnt;
  logic [FRAC_BITS-1:0] acc;
  logic [INT_W-1:0]     int_cur;
  logic [INT_W-1:0]     int_new;
  logic [FRAC_BITS:0]   acc_sum;

  assign int_cur     = div[DIV_W-1:FRAC_BITS];
  assign int_new     = load_div[DIV_W-1:FRAC_BITS];
  assign acc_sum     = {1'b0, acc} + {1'b0, div[FRAC_BITS-1:0]};
  assign sample_tick = enable && (cnt == '0);

  // A newly loaded divisor restarts the period from a clean accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= RST_DIV;
      cnt <= RST_INT - INT_W'(1);
      acc <= '0;
    end else if (load) begin
      div <= load_div;
      cnt <= int_new - INT_W'(1);
      acc <= '0;
    end else if (!enable) begin
      cnt <= int_cur - INT_W'(1);
      acc <= '0;
    end else if (cnt == '0) begin
      acc <= acc_sum[FRAC_BITS-1:0];
      cnt <= acc_sum[FRAC_BITS] ? int_cur : int_cur - INT_W'(1);
    end else begin
      cnt <= cnt - INT_W'(1);
    end
  end

endmodule

// File: rtl/uart_frac_baud_gen.sv
// Fractional-N UART tick generator: validates rate requests, applies them at
// baud boundaries and derives mid-bit and end-of-bit strobes from sample ticks.
module uart_frac_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100000000,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned DIV_W        = FRAC_BITS + $clog2(CLK_FREQ / (9600 * OVERSAMPLING) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [3:0]       baud_rate_select,
  input  logic [DIV_W-1:0] custom_divisor,
  input  logic             update_baud_rate,
  output logic             update_ack,
  output logic             cfg_error,
  output logic             update_pending,
  output logic [3:0]       active_select,
  output logic             sample_tick,
  output logic             mid_tick,
  output logic             baud_tick
);

  localparam int unsigned OS_W  = $clog2(OVERSAMPLING);
  localparam int unsigned INT_W = DIV_W - FRAC_BITS;
  localparam logic [DIV_W-1:0] DIV_9600 =
    DIV_W'(baud_divisor(CLK_FREQ, BAUD_RATES[0], OVERSAMPLING, FRAC_BITS));

  logic [DIV_W-1:0] div_table [NUM_RATES];

  for (genvar g = 0; g < NUM_RATES; g++) begin : g_rate
    localparam logic [DIV_W-1:0] DIV =
      DIV_W'(baud_divisor(CLK_FREQ, BAUD_RATES[g], OVERSAMPLING, FRAC_BITS));
    assign div_table[g] = DIV;
  end

  logic             req_valid;
  logic [DIV_W-1:0] req_div;
  logic             vld_p1;
  logic [DIV_W-1:0] pend_div_p1;
  logic [3:0]       pend_sel_p1;
  logic [OS_W-1:0]  os_cnt;
  logic             apply;

  always_comb begin
    req_valid = 1'b0;
    req_div   = custom_divisor;
    if (baud_rate_select < 4'(NUM_RATES)) begin
      req_valid = 1'b1;
      req_div   = div_table[baud_rate_select];
    end else if (baud_rate_select == BAUD_CUSTOM) begin
      req_valid = custom_divisor[DIV_W-1:FRAC_BITS] >= INT_W'(2);
    end
  end

  // ---- request stage -> pending (p1) ----
  always_ff @(posedge clk) begin
    if (update_baud_rate && req_valid) begin
      pend_div_p1 <= req_div;
      pend_sel_p1 <= baud_rate_select;
    end
  end

  // Disabled generators take a new rate immediately; running ones wait for the bit edge.
  assign apply          = vld_p1 && (!enable || baud_tick);
  assign update_ack     = apply;
  assign update_pending = vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      cfg_error     <= 1'b0;
      active_select <= 4'd0;
      os_cnt        <= '0;
    end else begin
      cfg_error <= update_baud_rate && !req_valid;
      if (apply) begin
        vld_p1        <= 1'b0;
        active_select <= pend_sel_p1;
      end
      if (update_baud_rate && req_valid) begin
        vld_p1 <= 1'b1;
      end
      if (!enable) begin
        os_cnt <= '0;
      end else if (sample_tick) begin
        os_cnt <= os_cnt + OS_W'(1);
      end
    end
  end

  // ---- pending (p1) -> active divisor ----
  frac_tick_divider #(
    .DIV_W     (DIV_W),
    .FRAC_BITS (FRAC_BITS),
    .RST_DIV   (DIV_9600)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (apply),
    .load_div    (pend_div_p1),
    .sample_tick (sample_tick)
  );

  assign mid_tick  = sample_tick && (os_cnt == OS_W'(OVERSAMPLING / 2 - 1));
  assign baud_tick = sample_tick && (os_cnt == OS_W'(OVERSAMPLING - 1));

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Scoreboard bench for uart_frac_baud_gen: expected tick spacing and strobe
// flags are queued from a reference model and compared as ticks appear.
module tb_uart_frac_baud_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  baud_rate_select;
  logic [17:0] custom_divisor;
  logic        update_baud_rate;
  logic        update_ack;
  logic        cfg_error;
  logic        update_pending;
  logic [3:0]  active_select;
  logic        sample_tick;
  logic        mid_tick;
  logic        baud_tick;

  always #5 clk = ~clk;

  uart_frac_baud_gen dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .baud_rate_select (baud_rate_select),
    .custom_divisor   (custom_divisor),
    .update_baud_rate (update_baud_rate),
    .update_ack       (update_ack),
    .cfg_error        (cfg_error),
    .update_pending   (update_pending),
    .active_select    (active_select),
    .sample_tick      (sample_tick),
    .mid_tick         (mid_tick),
    .baud_tick        (baud_tick)
  );

  typedef struct {
    int gap;
    bit mid;
    bit baud;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   last_tick = 0;
  logic s_sample, s_mid, s_baud, s_ack, s_err, s_pend;
  logic [3:0] s_sel;
  bit   ack_any;
  bit   pend_all;

  // Sample the current cycle at the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    s_sample = sample_tick;
    s_mid    = mid_tick;
    s_baud   = baud_tick;
    s_ack    = update_ack;
    s_err    = cfg_error;
    s_pend   = update_pending;
    s_sel    = active_select;
    if (update_ack === 1'b1) ack_any = 1'b1;
    if (update_pending !== 1'b1) pend_all = 1'b0;
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int gap, output bit ok);
    ok  = 1'b0;
    gap = -1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (s_sample === 1'b1) begin
        ok        = 1'b1;
        gap       = cyc_no - 1 - last_tick;
        last_tick = cyc_no - 1;
        break;
      end
    end
  endtask

  // Reference: intervals of I or I+1 driven by an 8-bit fraction accumulator, 16x oversampling.
  task automatic push_model(input int ip, input int fp, input int n);
    int   acc;
    int   gap;
    int   os;
    exp_t e;
    acc = 0;
    gap = ip;
    os  = 0;
    for (int k = 0; k < n; k++) begin
      e.gap  = gap;
      e.mid  = (os == 7);
      e.baud = (os == 15);
      sbq.push_back(e);
      acc = acc + fp;
      gap = ip + (acc >> 8);
      acc = acc & 255;
      os  = (os + 1) % 16;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({s_sample, s_mid, s_baud, s_ack, s_err, s_pend} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000", {s_sample, s_mid, s_baud, s_ack, s_err, s_pend});
    end
    checks++;
    if (s_sel !== 4'd0) begin
      errors++;
      $display("FAIL reset_select got %0d exp 0", s_sel);
    end
  endtask

  task automatic test_default_rate();
    exp_t e;
    int   gap;
    bit   ok;
    int   n;
    enable    = 1'b1;
    last_tick = cyc_no - 1;
    push_model(651, 11, 24);
    n = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(gap, ok);
      checks++;
      if (!ok || gap !== e.gap) begin
        errors++;
        $display("FAIL d9600_gap[%0d] got %0d exp %0d", n, gap, e.gap);
        sbq.delete();
      end
      checks++;
      if (s_mid !== e.mid) begin
        errors++;
        $display("FAIL d9600_mid[%0d] got %b exp %b", n, s_mid, e.mid);
      end
      checks++;
      if (s_baud !== e.baud) begin
        errors++;
        $display("FAIL d9600_baud[%0d] got %b exp %b", n, s_baud, e.baud);
      end
      n++;
    end
  endtask

  task automatic test_disabled_update();
    exp_t e;
    int   gap;
    bit   ok;
    int   n;
    int   sum;
    enable = 1'b0;
    step();
    step();
    baud_rate_select = 4'd4;
    update_baud_rate = 1'b1;
    step();
    update_baud_rate = 1'b0;
    checks++;
    if (s_ack !== 1'b0) begin
      errors++;
      $display("FAIL dis_ack_early got %b exp 0", s_ack);
    end
    step();
    checks++;
    if (s_ack !== 1'b1 || s_pend !== 1'b1) begin
      errors++;
      $display("FAIL dis_ack_next got ack=%b pend=%b exp ack=1 pend=1", s_ack, s_pend);
    end
    step();
    checks++;
    if (s_ack !== 1'b0 || s_pend !== 1'b0 || s_sel !== 4'd4) begin
      errors++;
      $display("FAIL dis_after got ack=%b pend=%b sel=%0d exp ack=0 pend=0 sel=4", s_ack, s_pend, s_sel);
    end
    enable    = 1'b1;
    last_tick = cyc_no - 1;
    push_model(54, 65, 257);
    n   = 0;
    sum = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(gap, ok);
      if (n > 0) sum += gap;
      checks++;
      if (!ok || gap !== e.gap) begin
        errors++;
        $display("FAIL d115k_gap[%0d] got %0d exp %0d", n, gap, e.gap);
        sbq.delete();
      end
      checks++;
      if (s_mid !== e.mid || s_baud !== e.baud) begin
        errors++;
        $display("FAIL d115k_flags[%0d] got mid=%b baud=%b exp mid=%b baud=%b", n, s_mid, s_baud, e.mid, e.baud);
      end
      n++;
    end
    checks++;
    if (sum !== 13889) begin
      errors++;
      $display("FAIL d115k_sum256 got %0d exp 13889", sum);
    end
  endtask

  task automatic test_midbit_update();
    exp_t e;
    int   gap;
    bit   ok;
    int   n;
    enable           = 1'b0;
    baud_rate_select = 4'd0;
    update_baud_rate = 1'b1;
    step();
    update_baud_rate = 1'b0;
    step();
    step();
    enable    = 1'b1;
    last_tick = cyc_no - 1;
    push_model(651, 11, 16);
    n = 0;
    while (sbq.size() > 1) begin
      if (n == 3) begin
        baud_rate_select = 4'd4;
        update_baud_rate = 1'b1;
        step();
        update_baud_rate = 1'b0;
        ack_any  = 1'b0;
        pend_all = 1'b1;
      end
      e = sbq.pop_front();
      wait_tick(gap, ok);
      checks++;
      if (!ok || gap !== e.gap || s_mid !== e.mid || s_baud !== e.baud) begin
        errors++;
        $display("FAIL mid_old[%0d] got gap=%0d mid=%b baud=%b exp gap=%0d mid=%b baud=%b", n, gap, s_mid, s_baud, e.gap, e.mid, e.baud);
      end
      n++;
    end
    checks++;
    if (pend_all !== 1'b1 || ack_any !== 1'b0) begin
      errors++;
      $display("FAIL mid_pending got pend_all=%b ack_any=%b exp 1 0", pend_all, ack_any);
    end
    e = sbq.pop_front();
    wait_tick(gap, ok);
    checks++;
    if (!ok || gap !== e.gap || s_baud !== 1'b1 || s_ack !== 1'b1) begin
      errors++;
      $display("FAIL mid_boundary got gap=%0d baud=%b ack=%b exp gap=%0d baud=1 ack=1", gap, s_baud, s_ack, e.gap);
    end
    step();
    checks++;
    if (s_pend !== 1'b0 || s_sel !== 4'd4) begin
      errors++;
      $display("FAIL mid_applied got pend=%b sel=%0d exp pend=0 sel=4", s_pend, s_sel);
    end
    push_model(54, 65, 3);
    n = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(gap, ok);
      checks++;
      if (!ok || gap !== e.gap || s_mid !== e.mid || s_baud !== e.baud) begin
        errors++;
        $display("FAIL mid_new[%0d] got gap=%0d mid=%b baud=%b exp gap=%0d mid=%b baud=%b", n, gap, s_mid, s_baud, e.gap, e.mid, e.baud);
        sbq.delete();
      end
      n++;
    end
  endtask

  task automatic test_invalid();
    logic [3:0]  codes [2];
    logic [17:0] divs [2];
    codes[0] = 4'd10;
    divs[0]  = 18'h00200;
    codes[1] = 4'd15;
    divs[1]  = 18'h00180;
    enable   = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      ack_any          = 1'b0;
      baud_rate_select = codes[i];
      custom_divisor   = divs[i];
      update_baud_rate = 1'b1;
      step();
      update_baud_rate = 1'b0;
      step();
      checks++;
      if (s_err !== 1'b1 || s_pend !== 1'b0 || s_sel !== 4'd4) begin
        errors++;
        $display("FAIL inv%0d_reject got err=%b pend=%b sel=%0d exp err=1 pend=0 sel=4", i, s_err, s_pend, s_sel);
      end
      step();
      checks++;
      if (s_err !== 1'b0 || ack_any !== 1'b0 || s_sel !== 4'd4) begin
        errors++;
        $display("FAIL inv%0d_after got err=%b ack_any=%b sel=%0d exp err=0 ack_any=0 sel=4", i, s_err, ack_any, s_sel);
      end
    end
  endtask

  task automatic test_custom();
    exp_t e;
    int   gap;
    bit   ok;
    int   n;
    baud_rate_select = 4'd15;
    custom_divisor   = 18'h00200;
    update_baud_rate = 1'b1;
    step();
    update_baud_rate = 1'b0;
    step();
    checks++;
    if (s_ack !== 1'b1 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL cust_ack got ack=%b err=%b exp ack=1 err=0", s_ack, s_err);
    end
    step();
    checks++;
    if (s_sel !== 4'd15) begin
      errors++;
      $display("FAIL cust_select got %0d exp 15", s_sel);
    end
    enable    = 1'b1;
    last_tick = cyc_no - 1;
    push_model(2, 0, 40);
    n = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(gap, ok);
      checks++;
      if (!ok || gap !== e.gap || s_mid !== e.mid || s_baud !== e.baud) begin
        errors++;
        $display("FAIL cust_tick[%0d] got gap=%0d mid=%b baud=%b exp gap=%0d mid=%b baud=%b", n, gap, s_mid, s_baud, e.gap, e.mid, e.baud);
        sbq.delete();
      end
      n++;
    end
  endtask

  task automatic test_reset_midbit();
    exp_t e;
    int   gap;
    bit   ok;
    int   n;
    baud_rate_select = 4'd4;
    update_baud_rate = 1'b1;
    step();
    update_baud_rate = 1'b0;
    step();
    checks++;
    if (s_pend !== 1'b1) begin
      errors++;
      $display("FAIL rstm_setup_pend got %b exp 1", s_pend);
    end
    rst = 1'b1;
    step();
    rst       = 1'b0;
    last_tick = cyc_no - 1;
    ack_any   = 1'b0;
    step();
    checks++;
    if ({s_sample, s_mid, s_baud, s_ack, s_err, s_pend} !== 6'b0 || s_sel !== 4'd0) begin
      errors++;
      $display("FAIL rstm_outputs got %b sel=%0d exp 000000 sel=0", {s_sample, s_mid, s_baud, s_ack, s_err, s_pend}, s_sel);
    end
    push_model(651, 11, 16);
    n = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(gap, ok);
      checks++;
      if (!ok || gap !== e.gap || s_mid !== e.mid || s_baud !== e.baud) begin
        errors++;
        $display("FAIL rstm_tick[%0d] got gap=%0d mid=%b baud=%b exp gap=%0d mid=%b baud=%b", n, gap, s_mid, s_baud, e.gap, e.mid, e.baud);
        sbq.delete();
      end
      n++;
    end
    checks++;
    if (ack_any !== 1'b0 || s_sel !== 4'd0) begin
      errors++;
      $display("FAIL rstm_no_apply got ack_any=%b sel=%0d exp ack_any=0 sel=0", ack_any, s_sel);
    end
  endtask

  initial begin
    rst              = 1'b1;
    enable           = 1'b0;
    baud_rate_select = 4'd0;
    custom_divisor   = 18'd0;
    update_baud_rate = 1'b0;
    ack_any          = 1'b0;
    pend_all         = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_default_rate();
    test_disabled_update();
    test_midbit_update();
    test_invalid();
    test_custom();
    test_reset_midbit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frac_baud_gen.md
# uart_frac_baud_gen

Parametrised fractional-N baud/sample tick generator for the UART transmit and receive paths. It replaces the integer-only divider with several additions: a fixed-point divisor with a fractional accumulator, a runtime-programmable custom divisor, glitch-free rate changes applied only at baud boundaries, and a mid-bit tick for the receiver's sampling point. It sits between the register interface and the UART TX/RX engines. All tick outputs are single-cycle pulses in the `clk` domain.

## Interface
- `CLK_FREQ`, default 100000000: input clock frequency in Hz.
- `OVERSAMPLING`, default 16: sample ticks per baud period. Must be a power of two, ≥ 4.
- `FRAC_BITS`, default 8: fractional bits of the divisor.
- `DIV_W`, default `FRAC_BITS + $clog2(CLK_FREQ/(9600*OVERSAMPLING)+1)`: divisor width (18 for the defaults).
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: run ticks. When low, the counters are held at their idle state.
- `baud_rate_select`, in, 4: rate code. Codes 0–8 select 9600/19200/38400/57600/115200/230400/460800/921600/1843200. Code 15 selects custom. Codes 9–14 are invalid.
- `custom_divisor`, in, `DIV_W`: unsigned fixed-point divisor (integer part `I`, `FRAC_BITS` fraction `F`). Used only with code 15.
- `update_baud_rate`, in, 1: one-cycle request to load the new rate.
- `update_ack`, out, 1: one-cycle pulse in the cycle the new divisor takes effect.
- `cfg_error`, out, 1: one-cycle pulse for a rejected request.
- `update_pending`, out, 1: high while an accepted request awaits a baud boundary.
- `active_select`, out, 4: code currently in use.
- `sample_tick`, out, 1: oversample strobe.
- `mid_tick`, out, 1: strobe at the bit centre.
- `baud_tick`, out, 1: strobe at the end of each bit period.

## Operation
- Table divisor: `D = round(CLK_FREQ·2^FRAC_BITS / (baud·OVERSAMPLING))`. Defaults give 9600 → 166667 (651 + 11/256) and 115200 → 13889 (54 + 65/256).
- Period counter: loads `I-1` (or `I` when the previous accumulate carried) and counts down. `sample_tick` fires in the cycle the count is 0.
- Fractional accumulator: on each `sample_tick`, `acc <= acc + F` (modulo 2^FRAC_BITS). A carry lengthens the next period by one cycle. Average period is exactly `D/2^FRAC_BITS` cycles.
- Oversample counter: 0..OVERSAMPLING-1, increments on `sample_tick` and wraps to 0.
  - `mid_tick` = `sample_tick` when the count is `OVERSAMPLING/2-1`.
  - `baud_tick` = `sample_tick` when the count is `OVERSAMPLING-1`.
- Request validation happens in the cycle `update_baud_rate` is high.
  - Codes 9–14: `cfg_error` pulses next cycle. The request is dropped and the existing pending state is untouched.
  - Code 15 with `I < 2`: `cfg_error` pulses and the request is dropped.
  - Valid requests set `update_pending` and latch the divisor and code. A newer valid request while pending overwrites the older one (last wins).
- Applying a pending request:
  - With `enable` high, it applies in the cycle of the next `baud_tick`. The new divisor governs the very next period, the accumulator clears, and `update_ack` pulses in that same cycle.
  - With `enable` low, it applies on the next cycle.
- `enable` low:
  - No ticks are produced.
  - The counter is held at the reload value.
  - The accumulator and oversample counter are at 0.
  - A partially elapsed bit is discarded.
- Reset values: all tick/ack/error outputs 0, `update_pending` 0, `active_select` 0, divisor = 9600 entry, all counters 0/reload.

## Timing
- First `sample_tick` occurs `I` cycles after the first cycle with `enable` high. Subsequent ticks are spaced `I` or `I+1` cycles apart.
- `cfg_error` and `update_pending` have a latency of 1 cycle from the request.
- `update_ack` is coincident with the `baud_tick` that closes the old-rate bit. The next `sample_tick` follows the new divisor.
- A request in the same cycle as a `baud_tick` is latched and applies at the following boundary, not the current one.
- `rst` mid-operation has priority over everything. It discards any pending request, and outputs take their reset values on the next edge.

## Structure
- Package `uart_pkg`:
  - `baud_sel_e` enum with codes 0–8 and `BAUD_CUSTOM = 15`.
  - Constant function `baud_divisor(clk_freq, baud, os, frac_bits)`.
  - Constant array of the nine table rates.
- Sub-module `frac_tick_divider`: period counter plus fractional accumulator, with `sample_tick` output and a divisor-load strobe. The top level holds the request/validation logic, the oversample counter and the boundary-apply logic.

## Test plan
- Reset then enable at 9600 (defaults): 256 consecutive `sample_tick` intervals sum to 166667 cycles, each interval 651 or 652. `baud_tick` fires every 16th sample, `mid_tick` at the 8th.
- Code 4 (115200) while disabled: `update_ack` fires the next cycle. 256 intervals sum to 13889, each interval 54 or 55.
- Code 4 requested mid-bit at 9600: `update_pending` stays high until the next `baud_tick`. `update_ack` is coincident with it, and the following interval is 54.
- Code 10: `cfg_error` pulses once, `active_select` stays unchanged, no ack. Custom divisor 0x00180 (1.5): rejected the same way.
- Custom divisor 0x00200 (2.0): `sample_tick` every 2 cycles, `baud_tick` every 32 cycles.
- `rst` asserted while a request is pending and mid-bit: the next cycle shows all outputs at 0, `active_select` 0, the pending request gone, and the 9600 timing resumes from the reload value.
